// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and frame helpers for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int KEY_W   = 4;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int FRAME_W = ROWS * COLS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HELD = 2'd2
    } key_state_t;

    // True when exactly one key is closed in the frame.
    function automatic logic single_key(input logic [FRAME_W-1:0] f);
        return (f != '0) && ((f & (f - FRAME_W'(1))) == '0);
    endfunction

    function automatic logic [KEY_W-1:0] key_index(input logic [FRAME_W-1:0] f);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (f[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a frame is accepted once it has been seen
// DEBOUNCE_SCANS times in a row; accept re-fires on every further stable frame.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic               int_osc,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_done,
    output logic [FRAME_W-1:0] accepted,
    output logic               accept
);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

    logic [FRAME_W-1:0] prev_frame;
    logic [3:0]         stable_cnt;
    logic [3:0]         next_cnt;

    always_comb begin
        next_cnt = 4'd1;
        if (frame == prev_frame) begin
            next_cnt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            prev_frame <= '0;
            stable_cnt <= '0;
            accepted   <= '0;
            accept     <= 1'b0;
        end else begin
            accept <= 1'b0;
            if (frame_done) begin
                prev_frame <= frame;
                stable_cnt <= next_cnt;
                if (next_cnt == CNT_MAX) begin
                    accepted <= frame;
                    accept   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, debounce and a
// single-entry key output with ready/valid handshake.
//
// state | meaning
// IDLE  | waiting for an accepted frame with exactly one key closed
// EMIT  | one cycle: load the key (or flag a drop if the slot is busy)
// HELD  | key reported; waiting for an all-released accepted frame
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic             int_osc,
    input  logic             rst,
    output logic [COLS-1:0]  col_n,
    input  logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_drop
);
    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [ROWS-1:0]    row_meta;
    logic [ROWS-1:0]    row_sync;
    logic [DIV_W-1:0]   div_cnt;
    logic               scan_tick;
    logic [1:0]         col;
    logic [FRAME_W-1:0] frame;
    logic               frame_done;
    logic [FRAME_W-1:0] accepted;
    logic               accept;
    key_state_t         state;
    key_state_t         state_nxt;

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign scan_tick = (div_cnt == DIV_LAST);
    assign col_n     = ~(COLS'(1) << col);

    // A column is sampled at the end of its drive period, so the rows have settled.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            col        <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= scan_tick ? '0 : div_cnt + DIV_W'(1);
            frame_done <= scan_tick && (col == 2'(COLS - 1));
            if (scan_tick) begin
                for (int r = 0; r < ROWS; r++) begin
                    frame[r*COLS + int'(col)] <= ~row_sync[r];
                end
                col <= col + 2'd1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .int_osc   (int_osc),
        .rst       (rst),
        .frame     (frame),
        .frame_done(frame_done),
        .accepted  (accepted),
        .accept    (accept)
    );

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && single_key(accepted)) state_nxt = ST_EMIT;
            ST_EMIT: state_nxt = ST_HELD;
            ST_HELD: if (accept && (accepted == '0)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A handshake in the EMIT cycle frees the slot, so the new key takes it directly.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_drop  <= 1'b0;
        end else begin
            key_drop <= 1'b0;
            if (state == ST_EMIT) begin
                if (!key_valid || key_ready) begin
                    key_code  <= key_index(accepted);
                    key_valid <= 1'b1;
                end else begin
                    key_drop <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule
